cpu_bus_router: RTL

Parametrised successor to the CPU bus slave port. It registers CPU bus transactions on `BUS_CLK` and decodes `BRAM_SELECT` into per-channel BRAM port strobes for up to `NUM_CH` channels. It adds a pipelined, latency-matched read-back path, per-channel write protection and a saturating error counter. It sits between the CPU bus pins and the BRAM banks (modulation, sequence, config, …).

---
 rtl/cpu_bus_router_if.sv | 48 ++++
 rtl/cpu_bus_router.sv | 132 +++++++++++++
 2 files changed

// File: rtl/cpu_bus_router_if.sv
// -----------------------------------------------------------------------------
// cpu_bus_router_if
// Groups every bus-side signal of cpu_bus_router: the CPU request inputs, the
// per-channel BRAM port (strobes, shared address/data, concatenated read data)
// and the read-back / error outputs.
//
// Modports:
//   slave  - the router. It samples the CPU request and CH_DOUT, and drives the
//            BRAM strobes, DATA_OUT, RD_VALID and ERR_CNT.
//   master - the environment. It plays both the CPU (request, WP_MASK, ERR_CLR)
//            and the BRAM banks (CH_DOUT).
// -----------------------------------------------------------------------------
interface cpu_bus_router_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 16,
  parameter int SEL_WIDTH  = 2,
  parameter int NUM_CH     = 4,
  parameter int ERR_WIDTH  = 8
);
  // CPU request
  logic                         EN;
  logic                         WE;
  logic [SEL_WIDTH-1:0]         BRAM_SELECT;
  logic [ADDR_WIDTH-1:0]        BRAM_ADDR;
  logic [DATA_WIDTH-1:0]        DATA_IN;
  logic [NUM_CH-1:0]            WP_MASK;
  logic                         ERR_CLR;
  // BRAM port
  logic [NUM_CH-1:0]            CH_EN;
  logic [NUM_CH-1:0]            CH_WE;
  logic [ADDR_WIDTH-1:0]        CH_ADDR;
  logic [DATA_WIDTH-1:0]        CH_DIN;
  logic [NUM_CH*DATA_WIDTH-1:0] CH_DOUT;
  // Read-back and status
  logic [DATA_WIDTH-1:0]        DATA_OUT;
  logic                         RD_VALID;
  logic [ERR_WIDTH-1:0]         ERR_CNT;

  modport slave (
    input  EN, WE, BRAM_SELECT, BRAM_ADDR, DATA_IN, WP_MASK, ERR_CLR, CH_DOUT,
    output CH_EN, CH_WE, CH_ADDR, CH_DIN, DATA_OUT, RD_VALID, ERR_CNT
  );

  modport master (
    output EN, WE, BRAM_SELECT, BRAM_ADDR, DATA_IN, WP_MASK, ERR_CLR, CH_DOUT,
    input  CH_EN, CH_WE, CH_ADDR, CH_DIN, DATA_OUT, RD_VALID, ERR_CNT
  );
endinterface

// File: rtl/cpu_bus_router.sv
// -----------------------------------------------------------------------------
// cpu_bus_router
// Registers CPU bus accesses and decodes BRAM_SELECT into one-hot BRAM port
// strobes for NUM_CH channels. Writes to protected channels and accesses to
// unimplemented channels are rejected and counted in a saturating ERR_CNT.
// Reads travel down a tag pipeline that matches the BRAM latency, so DATA_OUT /
// RD_VALID appear RD_LATENCY+1 edges after the access was sampled, in issue
// order, at up to one access per cycle.
//
// Ports:
//   BUS_CLK - sole clock
//   RST     - synchronous active-high reset
//   bus     - cpu_bus_router_if.slave (request in, BRAM strobes out, CH_DOUT in,
//             DATA_OUT / RD_VALID / ERR_CNT out)
// -----------------------------------------------------------------------------
module cpu_bus_router #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 16,
  parameter int SEL_WIDTH  = 2,
  parameter int NUM_CH     = 4,
  parameter int RD_LATENCY = 2,
  parameter int ERR_WIDTH  = 8
) (
  input  logic            BUS_CLK,
  input  logic            RST,
  cpu_bus_router_if.slave bus
);

  localparam logic [ERR_WIDTH-1:0] ERR_MAX = '1;

  // Per-read tag carried alongside the BRAM access.
  typedef struct packed {
    logic                 derr;
    logic [SEL_WIDTH-1:0] sel;
  } rd_tag_t;

  logic [NUM_CH-1:0]     ch_en_q, ch_en_d;
  logic [NUM_CH-1:0]     ch_we_q, ch_we_d;
  logic [ADDR_WIDTH-1:0] ch_addr_q, ch_addr_d;
  logic [DATA_WIDTH-1:0] ch_din_q, ch_din_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [ERR_WIDTH-1:0]  err_cnt_q, err_cnt_d;
  logic [RD_LATENCY:0]   rd_vld_q, rd_vld_d;
  rd_tag_t               rd_tag_q [RD_LATENCY+1];

  logic [NUM_CH-1:0]     sel_hit;
  logic                  dec_err, wp_hit, rd_req, wr_ok, reject;
  logic [DATA_WIDTH-1:0] rd_data;
  rd_tag_t               tail_tag;

  assign tail_tag = rd_tag_q[RD_LATENCY];

  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, so no
    // path through the block can leave a signal unassigned and infer a latch.
    sel_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.BRAM_SELECT == SEL_WIDTH'(i)) sel_hit[i] = 1'b1;
    end
    // A select with no matching implemented channel is a decode error.
    dec_err = ~|sel_hit;
    wp_hit  = |(sel_hit & bus.WP_MASK);
    rd_req  = bus.EN & ~bus.WE;
    wr_ok   = bus.EN & bus.WE & ~dec_err & ~wp_hit;
    reject  = bus.EN & (dec_err | (bus.WE & wp_hit));

    ch_en_d   = (wr_ok | (rd_req & ~dec_err)) ? sel_hit : '0;
    ch_we_d   = wr_ok ? sel_hit : '0;
    ch_addr_d = bus.EN ? bus.BRAM_ADDR : ch_addr_q;
    ch_din_d  = bus.EN ? bus.DATA_IN : ch_din_q;

    // Clear wins over a simultaneous rejection.
    err_cnt_d = err_cnt_q;
    if (bus.ERR_CLR)                        err_cnt_d = '0;
    else if (reject && err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + 1'b1;

    // Every read (including decode errors) enters the pipeline so the CPU
    // always gets an RD_VALID back.
    rd_vld_d = {rd_vld_q[RD_LATENCY-1:0], rd_req};

    rd_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (tail_tag.sel == SEL_WIDTH'(i)) rd_data = bus.CH_DOUT[i*DATA_WIDTH +: DATA_WIDTH];
    end
    if (tail_tag.derr) rd_data = '0;

    rd_valid_d = rd_vld_q[RD_LATENCY];
    data_out_d = rd_vld_q[RD_LATENCY] ? rd_data : data_out_q;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge BUS_CLK) begin
    if (RST) begin
      ch_en_q    <= '0;
      ch_we_q    <= '0;
      ch_addr_q  <= '0;
      ch_din_q   <= '0;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
      err_cnt_q  <= '0;
      rd_vld_q   <= '0;
    end else begin
      ch_en_q    <= ch_en_d;
      ch_we_q    <= ch_we_d;
      ch_addr_q  <= ch_addr_d;
      ch_din_q   <= ch_din_d;
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
      err_cnt_q  <= err_cnt_d;
      rd_vld_q   <= rd_vld_d;
    end
  end

  // NOTE: the tag payload is deliberately not reset; it is only ever consumed
  // when the matching rd_vld_q bit is set, and clearing those bits on reset is
  // what drops in-flight reads.
  always_ff @(posedge BUS_CLK) begin
    rd_tag_q[0] <= '{derr: dec_err, sel: bus.BRAM_SELECT};
    for (int j = 1; j <= RD_LATENCY; j++) rd_tag_q[j] <= rd_tag_q[j-1];
  end

  assign bus.CH_EN    = ch_en_q;
  assign bus.CH_WE    = ch_we_q;
  assign bus.CH_ADDR  = ch_addr_q;
  assign bus.CH_DIN   = ch_din_q;
  assign bus.DATA_OUT = data_out_q;
  assign bus.RD_VALID = rd_valid_q;
  assign bus.ERR_CNT  = err_cnt_q;

endmodule
